controle_busca: RTL and testbench

- Instruction-fetch sequencer for the 8-bit nRisc core.
- Owns the program counter and drives the address input of the instruction memory.
- The instruction memory updates its output on the clock falling edge. This block samples that output on the next rising edge, which gives 1-cycle read latency.
- Returned instructions are buffered in a small FIFO and handed to the decode stage through a valid/ready handshake. The block also handles branch redirects and HALT.

---
 rtl/controle_busca.sv | 182 ++++++++++++++++++
 tb/tb_controle_busca.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_busca.sv
// Instruction-fetch sequencer for the 8-bit nRisc core: owns the PC, fetches with 1-cycle latency, queues to decode.
// Optional out-of-range fetch fault is compiled in by defining FETCH_BOUND_CHECK_EN.
module controle_busca #(
  parameter logic [7:0]  RESET_PC  = 8'd0,
  parameter int unsigned DEPTH     = 2,
  parameter logic [7:0]  HALT_WORD = 8'hFF,
  parameter logic [7:0]  PROG_LAST = 8'd255
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] endereco,
  input  logic [7:0] instrucao_mem,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       desvio,
  input  logic [7:0] alvo,
  output logic       halted,
  output logic       fault
);
  localparam int unsigned CW = 3;
  localparam int unsigned AW = 8;

`ifdef FETCH_BOUND_CHECK_EN
  typedef enum logic [1:0] {ST_FETCH, ST_HALT, ST_FAULT} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH, ST_HALT} state_t;
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   pend_pc_q, pend_pc_d;
  logic [AW-1:0]   endereco_q, endereco_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [AW-1:0]   fifo_instr_q [DEPTH];
  logic [AW-1:0]   fifo_instr_d [DEPTH];
  logic [AW-1:0]   fifo_pc_q [DEPTH];
  logic [AW-1:0]   fifo_pc_d [DEPTH];
`ifdef FETCH_BOUND_CHECK_EN
  logic            fault_q, fault_d;
`endif

  logic            pop_c, push_c, credit_c, issue_c;
  logic [AW-1:0]   issue_addr_c;
  logic [CW-1:0]   wr_idx_c;

  // Next-state: redirect, issue credit, capture, HALT detection and FIFO shift.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = 1'b0;
    pend_pc_d    = pend_pc_q;
    endereco_d   = endereco_q;
    count_d      = count_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
`ifdef FETCH_BOUND_CHECK_EN
    fault_d      = fault_q;
`endif
    pop_c        = valid_q & instr_ready;
    push_c       = 1'b0;
    issue_c      = 1'b0;
    issue_addr_c = pc_q;
    wr_idx_c     = count_q - CW'(pop_c);
    // Entries already queued plus the one in flight, minus what leaves this cycle.
    credit_c     = (count_q + CW'(pend_q) - CW'(pop_c)) < CW'(DEPTH);

    if (desvio) begin
      count_d      = '0;
      valid_d      = 1'b0;
      state_d      = ST_FETCH;
      halted_d     = 1'b0;
      issue_addr_c = alvo;
`ifdef FETCH_BOUND_CHECK_EN
      if (alvo > PROG_LAST) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        fault_d = 1'b0;
        issue_c = 1'b1;
      end
`else
      issue_c = 1'b1;
`endif
    end else begin
      push_c = pend_q && (state_q == ST_FETCH);
      if (state_q == ST_FETCH) begin
`ifdef FETCH_BOUND_CHECK_EN
        if (pc_q > PROG_LAST) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          issue_c = credit_c;
        end
`else
        issue_c = credit_c;
`endif
        if (push_c && (instrucao_mem == HALT_WORD)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      end
      if (pop_c) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          fifo_instr_d[i] = fifo_instr_q[i+1];
          fifo_pc_d[i]    = fifo_pc_q[i+1];
        end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push_c && (wr_idx_c == CW'(i))) begin
          fifo_instr_d[i] = instrucao_mem;
          fifo_pc_d[i]    = pend_pc_q;
        end
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      valid_d = (count_d != '0);
    end

    if (issue_c) begin
      endereco_d = issue_addr_c;
      pend_d     = 1'b1;
      pend_pc_d  = issue_addr_c;
      pc_d       = issue_addr_c + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      endereco_q <= RESET_PC;
      count_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      endereco_q   <= endereco_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  logic unused_c;
  assign unused_c = ^PROG_LAST;
  assign fault    = 1'b0;
`endif

  assign endereco    = endereco_q;
  assign instr       = fifo_instr_q[0];
  assign instr_pc    = fifo_pc_q[0];
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_controle_busca.sv
// Scoreboard bench for controle_busca: stimulus queues expected {pc, word}; a negedge monitor pops on each accepted head.
module tb_controle_busca;
  localparam int unsigned DEPTH = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] endereco;
  logic [7:0] instrucao_mem = 8'h00;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       desvio;
  logic [7:0] alvo;
  logic       halted;
  logic       fault;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] e;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int p0 = 0;

`ifdef FETCH_BOUND_CHECK_EN
  controle_busca #(.DEPTH(DEPTH), .PROG_LAST(8'h80)) dut (
`else
  controle_busca #(.DEPTH(DEPTH)) dut (
`endif
    .clock(clock), .reset(reset), .endereco(endereco), .instrucao_mem(instrucao_mem),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .desvio(desvio), .alvo(alvo), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  // Instruction memory: output updates on the falling edge.
  always @(negedge clock) instrucao_mem = mem[endereco];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] pc, input logic [7:0] word);
    exp_q.push_back({pc, word});
  endtask

  // Monitor: every head the decode stage accepts must match the next expectation.
  always @(negedge clock) begin
    if (!reset && !desvio && instr_valid && instr_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop got pc=%h instr=%h expected none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        check8("pop_pc", instr_pc, e[15:8]);
        check8("pop_instr", instr, e[7:0]);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && (dut.count_q > 3'(DEPTH))) begin
      errors++;
      $display("FAIL fifo_overflow count=%0d limit=%0d", dut.count_q, DEPTH);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    reset = 1'b1; instr_ready = 1'b0; desvio = 1'b0; alvo = 8'h00;
    tick(); tick();
    check8("rst_endereco", endereco, 8'h00);
    check8("rst_valid", 8'(instr_valid), 8'd0);
    check8("rst_instr", instr, 8'h00);
    check8("rst_instr_pc", instr_pc, 8'h00);
    check8("rst_halted", 8'(halted), 8'd0);
    check8("rst_fault", 8'(fault), 8'd0);

    // Streaming
    for (int i = 0; i < 20; i++) push_exp(8'(i), 8'(i + 16));
    reset = 1'b0; instr_ready = 1'b1;
    tick();
    check8("stream_edge1_valid", 8'(instr_valid), 8'd0);
    check8("stream_edge1_endereco", endereco, 8'h00);
    tick();
    check8("stream_edge2_valid", 8'(instr_valid), 8'd1);
    check8("stream_edge2_instr", instr, 8'h10);
    check8("stream_edge2_pc", instr_pc, 8'h00);
    p0 = pops;
    repeat (8) tick();
    check8("stream_count", 8'(pops - p0), 8'd8);

    // Backpressure
    instr_ready = 1'b0;
    repeat (5) tick();
    check8("bp_endereco", endereco, 8'h09);
    check8("bp_valid", 8'(instr_valid), 8'd1);
    check8("bp_head_pc", instr_pc, 8'h08);
    check8("bp_no_pop", 8'(pops - p0), 8'd8);
    instr_ready = 1'b1;
    repeat (6) tick();
    check8("bp_resume_count", 8'(pops - p0), 8'd14);

    // Redirect with a full FIFO
    instr_ready = 1'b0;
    repeat (3) tick();
    check8("redir_full_valid", 8'(instr_valid), 8'd1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_exp(8'(8'h40 + i), 8'(8'h50 + i));
    desvio = 1'b1; alvo = 8'h40;
    tick();
    check8("redir_flush_valid", 8'(instr_valid), 8'd0);
    check8("redir_endereco", endereco, 8'h40);
    desvio = 1'b0; instr_ready = 1'b1; p0 = pops;
    tick();
    check8("redir_first_valid", 8'(instr_valid), 8'd1);
    check8("redir_first_pc", instr_pc, 8'h40);
    repeat (3) tick();
    instr_ready = 1'b0;
    check8("redir_count", 8'(pops - p0), 8'd3);

    // HALT at address 3
    mem[3] = 8'hFF;
    reset = 1'b1; exp_q.delete();
    tick();
    reset = 1'b0; instr_ready = 1'b1; p0 = pops;
    push_exp(8'h00, 8'h10); push_exp(8'h01, 8'h11); push_exp(8'h02, 8'h12); push_exp(8'h03, 8'hFF);
    repeat (4) tick();
    check8("halt_before", 8'(halted), 8'd0);
    tick();
    check8("halt_set", 8'(halted), 8'd1);
    check8("halt_endereco", endereco, 8'h04);
    repeat (4) tick();
    check8("halt_frozen_endereco", endereco, 8'h04);
    check8("halt_still", 8'(halted), 8'd1);
    check8("halt_delivered", 8'(pops - p0), 8'd4);
    check8("halt_queue_empty", 8'(exp_q.size()), 8'd0);
    check8("halt_drained", 8'(instr_valid), 8'd0);
    mem[3] = 8'h13;
    for (int i = 0; i < 4; i++) push_exp(8'(i), 8'(i + 16));
    desvio = 1'b1; alvo = 8'h00; p0 = pops;
    tick();
    check8("halt_restart_cleared", 8'(halted), 8'd0);
    desvio = 1'b0;
    repeat (5) tick();
    instr_ready = 1'b0;
    check8("halt_restart_count", 8'(pops - p0), 8'd4);
    check8("halt_restart_queue", 8'(exp_q.size()), 8'd0);

`ifdef FETCH_BOUND_CHECK_EN
    // Out-of-range fetch
    push_exp(8'h7F, 8'h8F); push_exp(8'h80, 8'h90);
    desvio = 1'b1; alvo = 8'h7F; p0 = pops;
    tick();
    desvio = 1'b0; instr_ready = 1'b1;
    repeat (6) tick();
    check8("fault_set", 8'(fault), 8'd1);
    check8("fault_count", 8'(pops - p0), 8'd2);
    check8("fault_queue", 8'(exp_q.size()), 8'd0);
    check8("fault_endereco", endereco, 8'h80);
    instr_ready = 1'b0;
    desvio = 1'b1; alvo = 8'h10;
    tick();
    desvio = 1'b0;
    check8("fault_cleared", 8'(fault), 8'd0);
`else
    // PC wrap
    push_exp(8'hFE, 8'h0E); push_exp(8'hFF, 8'h0F); push_exp(8'h00, 8'h10); push_exp(8'h01, 8'h11);
    desvio = 1'b1; alvo = 8'hFE; p0 = pops;
    tick();
    desvio = 1'b0; instr_ready = 1'b1;
    repeat (5) tick();
    instr_ready = 1'b0;
    check8("wrap_count", 8'(pops - p0), 8'd4);
    check8("wrap_queue", 8'(exp_q.size()), 8'd0);
    check8("wrap_fault", 8'(fault), 8'd0);
`endif

    // Reset mid-stream
    exp_q.delete();
    desvio = 1'b1; alvo = 8'h20;
    tick();
    desvio = 1'b0;
    tick(); tick();
    check8("mid_valid_before", 8'(instr_valid), 8'd1);
    reset = 1'b1; exp_q.delete();
    for (int i = 0; i < 4; i++) push_exp(8'(i), 8'(i + 16));
    tick();
    check8("mid_rst_valid", 8'(instr_valid), 8'd0);
    check8("mid_rst_endereco", endereco, 8'h00);
    check8("mid_rst_instr_pc", instr_pc, 8'h00);
    check8("mid_rst_instr", instr, 8'h00);
    reset = 1'b0; instr_ready = 1'b1; p0 = pops;
    tick(); tick();
    check8("mid_restart_valid", 8'(instr_valid), 8'd1);
    check8("mid_restart_pc", instr_pc, 8'h00);
    repeat (3) tick();
    instr_ready = 1'b0;
    check8("mid_restart_count", 8'(pops - p0), 8'd3);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
